sd_vhd_arbiter: RTL

- Shares the single HPS block-transfer channel (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_din) between the two virtual SD-card images (C: and D:).
- Replaces the combinational LBA/din muxing with a registered round-robin arbiter. One transaction is in flight at a time; LBA is frozen per transaction; a watchdog recovers from lost acks.
- Sits between the two sd_card instances and hps_io, in the clk_sys domain.

---
 rtl/sd_vhd_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sd_vhd_arbiter.sv
// Registered round-robin arbiter sharing the HPS block-transfer channel
// between the two virtual SD-card images. One transaction is in flight at
// a time, the LBA is captured at grant, and a watchdog recovers lost acks.
module sd_vhd_arbiter #(
    parameter int unsigned TIMEOUT = 28000000,
    parameter int unsigned LBA_W   = 32
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [1:0]       c_rd,
    input  logic [1:0]       c_wr,
    input  logic [LBA_W-1:0] c_lba0,
    input  logic [LBA_W-1:0] c_lba1,
    input  logic [15:0]      c_din0,
    input  logic [15:0]      c_din1,
    output logic [1:0]       c_ack,
    output logic [LBA_W-1:0] sd_lba,
    output logic [1:0]       sd_rd,
    output logic [1:0]       sd_wr,
    input  logic [1:0]       sd_ack,
    output logic [15:0]      sd_buff_din,
    output logic             busy,
    output logic             grant,
    output logic             timeout_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_GAP
    } state_t;

    state_t           r_state;
    logic             r_grant;
    logic             r_prio;
    logic             r_busy;
    logic             r_tout;
    logic             r_upd_prio;
    logic [1:0]       r_rd;
    logic [1:0]       r_wr;
    logic [LBA_W-1:0] r_lba;
    logic [CW-1:0]    r_cnt;

    logic [1:0]       w_pend;
    logic             w_sel;
    logic [1:0]       w_sel_hot;
    logic             w_sel_wr;
    logic [LBA_W-1:0] w_sel_lba;
    logic             w_pend_g;
    logic             w_ack_g;
    logic             w_last;

    // Channel selection and per-grant status, evaluated every cycle
    always_comb begin
        w_pend    = c_rd | c_wr;
        w_sel     = (&w_pend) ? r_prio : w_pend[1];
        w_sel_hot = w_sel ? 2'b10 : 2'b01;
        w_sel_wr  = c_wr[w_sel];
        w_sel_lba = w_sel ? c_lba1 : c_lba0;
        w_pend_g  = w_pend[r_grant];
        w_ack_g   = sd_ack[r_grant];
        w_last    = (r_cnt == CW'(TIMEOUT - 1));
    end

    // Transaction FSM with registered host-side outputs and watchdog
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_prio     <= 1'b0;
            r_busy     <= 1'b0;
            r_tout     <= 1'b0;
            r_upd_prio <= 1'b0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_lba      <= '0;
            r_cnt      <= '0;
        end else begin
            r_tout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|w_pend) begin
                        r_grant    <= w_sel;
                        r_lba      <= w_sel_lba;
                        r_rd       <= w_sel_wr ? 2'b00 : w_sel_hot;
                        r_wr       <= w_sel_wr ? w_sel_hot : 2'b00;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_upd_prio <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A watchdog expiry outranks an ack arriving on the same
                    // cycle so the counter can never wrap past TIMEOUT-1.
                    if (w_ack_g && !w_last) begin
                        r_rd    <= '0;
                        r_wr    <= '0;
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_XFER;
                    end else if (!w_pend_g) begin
                        r_rd       <= '0;
                        r_wr       <= '0;
                        r_upd_prio <= 1'b0;
                        r_state    <= S_GAP;
                    end else if (w_last) begin
                        r_rd    <= '0;
                        r_wr    <= '0;
                        r_tout  <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (!w_ack_g) begin
                        r_state <= S_GAP;
                    end else if (w_last) begin
                        r_tout  <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    r_busy <= 1'b0;
                    if (r_upd_prio) begin
                        r_prio <= ~r_grant;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Ack forwarding and data routing follow the current grant
    always_comb begin
        c_ack       = sd_ack & {2{r_busy}} & (r_grant ? 2'b10 : 2'b01);
        sd_buff_din = r_grant ? c_din1 : c_din0;
        sd_lba      = r_lba;
        sd_rd       = r_rd;
        sd_wr       = r_wr;
        busy        = r_busy;
        grant       = r_grant;
        timeout_err = r_tout;
    end

endmodule
